// File: rtl/pipe_chain_if.sv
// Instruction pipeline chain bus: fetch-side inputs, per-stage controls,
// and the registered stage contents and retire count returned to the core.
interface pipe_chain_if #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int CNT_W  = 32
);
    localparam int OCC_W = $clog2(STAGES + 1);

    logic [WIDTH-1:0]        inst_in;
    logic                    valid_in;
    logic [STAGES-1:0]       stall;
    logic [STAGES-1:0]       flush;
    logic [STAGES*WIDTH-1:0] inst_out;
    logic [STAGES-1:0]       valid_out;
    logic [OCC_W-1:0]        occupancy;
    logic [CNT_W-1:0]        retire_cnt;

    // Fetch/control side: drives instructions, stalls and flushes.
    modport master (
        output inst_in, valid_in, stall, flush,
        input  inst_out, valid_out, occupancy, retire_cnt
    );

    // Pipeline side: the register chain itself.
    modport slave (
        input  inst_in, valid_in, stall, flush,
        output inst_out, valid_out, occupancy, retire_cnt
    );
endinterface

// File: rtl/pipe_chain.sv
// Parametrised instruction pipeline register chain with per-stage valid,
// partial stall with bubble insertion, per-stage flush, NOP fill, occupancy
// count and a saturating retire counter.
module pipe_chain #(
    parameter int               WIDTH  = 32,
    parameter int               STAGES = 3,
    parameter logic [WIDTH-1:0] NOP    = WIDTH'(32'h00000013),
    parameter int               CNT_W  = 32
) (
    input  logic         clk,
    input  logic         reset,
    pipe_chain_if.slave  bus
);
    localparam int OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] w_hold;
    logic [STAGES-1:0] w_valid;
    logic [WIDTH-1:0]  w_inst [STAGES];
    logic              w_retire;
    logic [OCC_W-1:0]  w_occ;
    logic [CNT_W-1:0]  r_cnt;

    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_stage
            logic             r_v;
            logic [WIDTH-1:0] r_d;
            logic             w_src_v;
            logic [WIDTH-1:0] w_src_d;

            // A stall at stage j freezes j and everything upstream of it.
            assign w_hold[g] = |(bus.stall >> g);

            if (g == 0) begin : g_src
                assign w_src_v = bus.valid_in;
                assign w_src_d = bus.valid_in ? bus.inst_in : NOP;
            end else begin : g_src
                // A held upstream stage feeds a bubble into a moving stage.
                assign w_src_v = w_hold[g-1] ? 1'b0 : w_valid[g-1];
                assign w_src_d = w_hold[g-1] ? NOP  : w_inst[g-1];
            end

            // Stage register: flush beats hold; a held stage simply keeps its value.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_v <= 1'b0;
                    r_d <= NOP;
                end else if (bus.flush[g]) begin
                    r_v <= 1'b0;
                    r_d <= NOP;
                end else if (!w_hold[g]) begin
                    r_v <= w_src_v;
                    r_d <= w_src_d;
                end
            end

            assign w_valid[g] = r_v;
            assign w_inst[g]  = r_d;
            assign bus.inst_out[g*WIDTH +: WIDTH] = r_d;
        end
    endgenerate

    // An instruction retires only if it leaves the last stage unkilled.
    assign w_retire = w_valid[STAGES-1] & ~bus.stall[STAGES-1] & ~bus.flush[STAGES-1];

    // Retire counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_retire && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Occupancy is the popcount of the registered valid bits.
    always_comb begin
        w_occ = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_occ = w_occ + OCC_W'(w_valid[i]);
        end
    end

    assign bus.valid_out  = w_valid;
    assign bus.occupancy  = w_occ;
    assign bus.retire_cnt = r_cnt;
endmodule
